exe_mem_reg: RTL and testbench

Pipeline register between the EXE stage and the MEM stage of the ARM core with cache. It captures the EXE-stage results each cycle and presents them, registered, to the MEM stage and its cache controller. While the MEM stage raises `mem_freeze` (cache miss, SRAM access in progress), it holds its contents. It also tracks stall length with a watchdog, and optionally collects memory-stall statistics.

---
 rtl/arm_pkg.sv | 39 +++
 rtl/stall_monitor.sv | 135 +++++++++++++
 rtl/exe_mem_reg.sv | 126 ++++++++++++
 tb/tb_exe_mem_reg.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_pkg
//  Description : Shared definitions for the ARM core pipeline registers.
//                Register/word widths, the EXE/MEM register state encoding
//                and the bundled EXE->MEM payload.
//  Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int WORD_W     = 32;

   // EXE/MEM register operating state.
   typedef enum logic [0:0] {
      RUN   = 1'b0,
      STALL = 1'b1
   } exe_mem_state_t;

   // Everything the EXE stage hands to the MEM stage in one cycle.
   typedef struct packed {
      logic                  wb_en;
      logic                  mem_r_en;
      logic                  mem_w_en;
      logic [REG_ADDR_W-1:0] dest;
      logic [WORD_W-1:0]     alu_res;
      logic [WORD_W-1:0]     val_rm;
   } exe_mem_bus_t;

   // An empty slot: no writeback, no memory request.
   localparam exe_mem_bus_t EXE_MEM_BUBBLE = '0;

   // True when the entry drives a load or store into the cache.
   function automatic logic is_mem_op(input exe_mem_bus_t b);
      return b.mem_r_en | b.mem_w_en;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stall_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : stall_monitor
//  Description : Tracks the length of the current MEM freeze, raises a sticky
//                watchdog flag when a single freeze reaches STALL_TIMEOUT
//                cycles, and optionally gathers stall statistics.
//  Config      : EXE_MEM_STALL_STATS_EN - when defined, the stall_cycles,
//                mem_ops and max_stall counters are built; otherwise those
//                outputs are tied to zero.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                stall_active_i      - register currently in STALL
//                mem_freeze_i        - MEM stage freeze request this edge
//                stall_done_i        - completion pulse (entry left the reg)
//                stall_timeout_o     - sticky watchdog flag
//                stall_cycles_o      - total cycles spent in STALL
//                mem_ops_o           - completed memory operations
//                max_stall_o         - longest finished freeze, in cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module stall_monitor #(
   parameter int STALL_TIMEOUT = 1024,
   parameter int STALL_CNT_W   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_active_i,
   input  logic        mem_freeze_i,
   input  logic        stall_done_i,
   output logic        stall_timeout_o,
   output logic [31:0] stall_cycles_o,
   output logic [31:0] mem_ops_o,
   output logic [15:0] max_stall_o
);

   localparam logic [STALL_CNT_W-1:0] TIMEOUT_CNT = STALL_CNT_W'(STALL_TIMEOUT);

   logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
   logic                   timeout_q, timeout_d;

   // Counter holds the length of the freeze in progress: 1 on the entry
   // edge, saturating increment while it lasts, cleared on release.
   always_comb begin
      cnt_d = '0;
      if (mem_freeze_i) begin
         if (!stall_active_i) begin
            cnt_d = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
         end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Compared against the next count so the flag appears in the same cycle
   // the counter first shows STALL_TIMEOUT.
   always_comb begin
      timeout_d = timeout_q;
      if (cnt_d == TIMEOUT_CNT) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign stall_timeout_o = timeout_q;

`ifdef EXE_MEM_STALL_STATS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] mem_ops_q,      mem_ops_d;
   logic [15:0] max_stall_q,    max_stall_d;
   logic [15:0] w_fin16;
   logic        w_release;

   // Finished stall length clipped to the 16-bit statistic.
   if (STALL_CNT_W > 16) begin : g_cnt_wide
      assign w_fin16 = (|cnt_q[STALL_CNT_W-1:16]) ? 16'hFFFF : cnt_q[15:0];
   end else if (STALL_CNT_W == 16) begin : g_cnt_eq
      assign w_fin16 = cnt_q;
   end else begin : g_cnt_narrow
      assign w_fin16 = {{(16-STALL_CNT_W){1'b0}}, cnt_q};
   end

   assign w_release = stall_active_i & ~mem_freeze_i;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      mem_ops_d      = mem_ops_q;
      max_stall_d    = max_stall_q;
      if (stall_active_i && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (stall_done_i) begin
         mem_ops_d = mem_ops_q + 32'd1;
      end
      if (w_release && (w_fin16 > max_stall_q)) begin
         max_stall_d = w_fin16;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         mem_ops_q      <= '0;
         max_stall_q    <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         mem_ops_q      <= mem_ops_d;
         max_stall_q    <= max_stall_d;
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign mem_ops_o      = mem_ops_q;
   assign max_stall_o    = max_stall_q;
`else
   // Completion pulse only feeds the statistics.
   logic unused_stall_done;
   assign unused_stall_done = stall_done_i;

   assign stall_cycles_o = '0;
   assign mem_ops_o      = '0;
   assign max_stall_o    = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/exe_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module      : exe_mem_reg
//  Description : EXE -> MEM pipeline register. Captures the EXE results each
//                cycle and holds them, unchanged, while the MEM stage asserts
//                mem_freeze (cache miss / SRAM access). Includes a stall
//                watchdog and optional stall statistics.
//  Config      : EXE_MEM_STALL_STATS_EN - enables stall_cycles, mem_ops and
//                max_stall counters (outputs read 0 otherwise).
//  Ports       : clk, rst                         - clock, sync active-high rst
//                wb_en_in..val_rm_in              - EXE stage results
//                mem_freeze                       - MEM not ready, hold
//                wb_en_out..val_rm_out            - registered copy to MEM
//                stall_active                     - holding due to freeze
//                stall_timeout                    - sticky watchdog flag
//                stall_cycles, mem_ops, max_stall - statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module exe_mem_reg
   import arm_pkg::*;
#(
   parameter int STALL_TIMEOUT = 1024,
   parameter int STALL_CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_en_in,
   input  logic                  mem_r_en_in,
   input  logic                  mem_w_en_in,
   input  logic [REG_ADDR_W-1:0] dest_in,
   input  logic [WORD_W-1:0]     alu_res_in,
   input  logic [WORD_W-1:0]     val_rm_in,
   input  logic                  mem_freeze,
   output logic                  wb_en_out,
   output logic                  mem_r_en_out,
   output logic                  mem_w_en_out,
   output logic [REG_ADDR_W-1:0] dest_out,
   output logic [WORD_W-1:0]     alu_res_out,
   output logic [WORD_W-1:0]     val_rm_out,
   output logic                  stall_active,
   output logic                  stall_timeout,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           mem_ops,
   output logic [15:0]           max_stall
);

   exe_mem_state_t state_q, state_d;
   exe_mem_bus_t   bus_q,   bus_d;
   exe_mem_bus_t   w_bus_in;
   logic           w_done;

   assign w_bus_in = '{
      wb_en:    wb_en_in,
      mem_r_en: mem_r_en_in,
      mem_w_en: mem_w_en_in,
      dest:     dest_in,
      alu_res:  alu_res_in,
      val_rm:   val_rm_in
   };

   // mem_freeze is a direct hold enable: any edge without it captures the
   // new EXE entry, including the edge that ends a stall.
   always_comb begin
      state_d = state_q;
      bus_d   = bus_q;
      w_done  = 1'b0;
      case (state_q)
         RUN: begin
            if (mem_freeze) begin
               state_d = STALL;
            end else begin
               bus_d  = w_bus_in;
               // Departing load/store has been accepted by MEM.
               w_done = is_mem_op(bus_q);
            end
         end
         STALL: begin
            if (!mem_freeze) begin
               bus_d   = w_bus_in;
               state_d = RUN;
               // Every released stall counts as a completed access.
               w_done  = 1'b1;
            end
         end
         default: begin
            state_d = RUN;
            bus_d   = EXE_MEM_BUBBLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         bus_q   <= EXE_MEM_BUBBLE;
      end else begin
         state_q <= state_d;
         bus_q   <= bus_d;
      end
   end

   assign wb_en_out    = bus_q.wb_en;
   assign mem_r_en_out = bus_q.mem_r_en;
   assign mem_w_en_out = bus_q.mem_w_en;
   assign dest_out     = bus_q.dest;
   assign alu_res_out  = bus_q.alu_res;
   assign val_rm_out   = bus_q.val_rm;
   assign stall_active = (state_q == STALL);

   stall_monitor #(
      .STALL_TIMEOUT (STALL_TIMEOUT),
      .STALL_CNT_W   (STALL_CNT_W)
   ) u_stall_monitor (
      .clk             (clk),
      .rst             (rst),
      .stall_active_i  (stall_active),
      .mem_freeze_i    (mem_freeze),
      .stall_done_i    (w_done),
      .stall_timeout_o (stall_timeout),
      .stall_cycles_o  (stall_cycles),
      .mem_ops_o       (mem_ops),
      .max_stall_o     (max_stall)
   );

endmodule
`default_nettype wire

// File: tb/tb_exe_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exe_mem_reg
//  Description : Self-checking bench for exe_mem_reg. Random EXE traffic is
//                applied in directed phases (plain flow, load stall, watchdog,
//                reset mid-stall, store stalls) followed by a random phase,
//                and every cycle is compared against a behavioural model.
//  Config      : EXE_MEM_STALL_STATS_EN - selects expected statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_mem_reg;

   localparam int TIMEOUT = 8;
   localparam int CNT_MAX = 65535;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in, mem_freeze;
   logic [3:0]  dest_in;
   logic [31:0] alu_res_in, val_rm_in;
   logic        wb_en_out, mem_r_en_out, mem_w_en_out;
   logic [3:0]  dest_out;
   logic [31:0] alu_res_out, val_rm_out;
   logic        stall_active, stall_timeout;
   logic [31:0] stall_cycles, mem_ops;
   logic [15:0] max_stall;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: the last accepted EXE entry plus freeze history.
   logic        m_wb, m_r, m_w;
   logic [3:0]  m_dest;
   logic [31:0] m_alu, m_val;
   bit          m_frozen;     // previous edge saw freeze (register holding)
   bit          m_timeout;
   longint      m_run;        // length of the freeze in progress
   longint      m_cycles, m_ops, m_max;

   exe_mem_reg #(
      .STALL_TIMEOUT (TIMEOUT),
      .STALL_CNT_W   (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wb_en_in      (wb_en_in),
      .mem_r_en_in   (mem_r_en_in),
      .mem_w_en_in   (mem_w_en_in),
      .dest_in       (dest_in),
      .alu_res_in    (alu_res_in),
      .val_rm_in     (val_rm_in),
      .mem_freeze    (mem_freeze),
      .wb_en_out     (wb_en_out),
      .mem_r_en_out  (mem_r_en_out),
      .mem_w_en_out  (mem_w_en_out),
      .dest_out      (dest_out),
      .alu_res_out   (alu_res_out),
      .val_rm_out    (val_rm_out),
      .stall_active  (stall_active),
      .stall_timeout (stall_timeout),
      .stall_cycles  (stall_cycles),
      .mem_ops       (mem_ops),
      .max_stall     (max_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rand_in(input bit allow_mem);
      wb_en_in    = 1'($urandom);
      mem_r_en_in = allow_mem ? 1'($urandom) : 1'b0;
      mem_w_en_in = allow_mem ? 1'($urandom) : 1'b0;
      dest_in     = 4'($urandom);
      alu_res_in  = $urandom;
      val_rm_in   = $urandom;
   endtask

   // One clock edge seen from the outside: what the MEM stage should observe.
   task automatic model_edge();
      if (rst) begin
         {m_wb, m_r, m_w, m_dest, m_alu, m_val} = '0;
         m_frozen  = 0;
         m_timeout = 0;
         m_run     = 0;
         m_cycles  = 0;
         m_ops     = 0;
         m_max     = 0;
      end else begin
         if (m_frozen && m_cycles < 64'hFFFF_FFFF) m_cycles++;
         if (mem_freeze) begin
            m_run = m_frozen ? ((m_run < CNT_MAX) ? m_run + 1 : m_run) : 1;
            if (m_run == TIMEOUT) m_timeout = 1;
            m_frozen = 1;
         end else begin
            if (m_frozen) begin
               m_ops++;
               if (m_run > m_max) m_max = m_run;
            end else if (m_r || m_w) begin
               m_ops++;
            end
            m_wb = wb_en_in; m_r = mem_r_en_in; m_w = mem_w_en_in;
            m_dest = dest_in; m_alu = alu_res_in; m_val = val_rm_in;
            m_run = 0;
            m_frozen = 0;
         end
      end
   endtask

   task automatic check_all();
      chk("wb_en_out",     32'(wb_en_out),     32'(m_wb));
      chk("mem_r_en_out",  32'(mem_r_en_out),  32'(m_r));
      chk("mem_w_en_out",  32'(mem_w_en_out),  32'(m_w));
      chk("dest_out",      32'(dest_out),      32'(m_dest));
      chk("alu_res_out",   alu_res_out,        m_alu);
      chk("val_rm_out",    val_rm_out,         m_val);
      chk("stall_active",  32'(stall_active),  32'(m_frozen));
      chk("stall_timeout", 32'(stall_timeout), 32'(m_timeout));
`ifdef EXE_MEM_STALL_STATS_EN
      chk("stall_cycles",  stall_cycles,       32'(m_cycles));
      chk("mem_ops",       mem_ops,            32'(m_ops));
      chk("max_stall",     32'(max_stall),     32'(m_max));
`else
      chk("stall_cycles",  stall_cycles,       32'd0);
      chk("mem_ops",       mem_ops,            32'd0);
      chk("max_stall",     32'(max_stall),     32'd0);
`endif
   endtask

   task automatic step(input logic frz);
      mem_freeze = frz;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      rst = 1'b1;
      mem_freeze = 1'b0;
      rand_in(1);
      m_frozen = 0; m_timeout = 0; m_run = 0; m_cycles = 0; m_ops = 0; m_max = 0;
      {m_wb, m_r, m_w, m_dest, m_alu, m_val} = '0;

      // Reset state, with garbage on the inputs.
      step(0);
      rand_in(1);
      step(1);
      rst = 1'b0;

      // Four ALU ops, no freeze.
      for (int i = 0; i < 4; i++) begin
         rand_in(0);
         step(0);
         chk("alu_flow_stall_active", 32'(stall_active), 32'd0);
      end

      // Load to 0x40 held through a 5-cycle freeze.
      rand_in(0);
      mem_r_en_in = 1'b1;
      alu_res_in  = 32'h0000_0040;
      step(0);
      for (int i = 0; i < 5; i++) begin
         rand_in(1);
         step(1);
         chk("load_hold_addr", alu_res_out, 32'h0000_0040);
         chk("load_hold_ren",  32'(mem_r_en_out), 32'd1);
      end
      rand_in(0);
      step(0);
`ifdef EXE_MEM_STALL_STATS_EN
      chk("load_stall_cycles", stall_cycles, 32'd5);
      chk("load_mem_ops",      mem_ops,      32'd1);
      chk("load_max_stall",    32'(max_stall), 32'd5);
`endif

      // Watchdog: 10-cycle freeze against a timeout of 8.
      for (int i = 1; i <= 10; i++) begin
         rand_in(1);
         step(1);
         if (i == TIMEOUT - 1) chk("wdog_before", 32'(stall_timeout), 32'd0);
         if (i == TIMEOUT)     chk("wdog_at",     32'(stall_timeout), 32'd1);
      end
      for (int i = 0; i < 3; i++) begin
         rand_in(1);
         step(0);
         chk("wdog_sticky", 32'(stall_timeout), 32'd1);
      end
      rst = 1'b1;
      step(0);
      chk("wdog_cleared", 32'(stall_timeout), 32'd0);
      rst = 1'b0;

      // Reset on the third cycle of a stall.
      rand_in(1);
      step(0);
      step(1);
      step(1);
      rst = 1'b1;
      step(1);
      chk("rst_mid_stall_active", 32'(stall_active), 32'd0);
      chk("rst_mid_stall_alu",    alu_res_out,       32'd0);
      rst = 1'b0;

      // Store of 0xDEADBEEF, then stalls of 3 and 7 cycles.
      rand_in(0);
      mem_w_en_in = 1'b1;
      val_rm_in   = 32'hDEAD_BEEF;
      step(0);
      for (int i = 0; i < 3; i++) begin
         rand_in(1);
         step(1);
         chk("store_hold_data", val_rm_out, 32'hDEAD_BEEF);
      end
      rand_in(0);
      step(0);
      for (int i = 0; i < 7; i++) begin
         rand_in(1);
         step(1);
      end
      rand_in(0);
      step(0);
`ifdef EXE_MEM_STALL_STATS_EN
      chk("store_max_stall", 32'(max_stall), 32'd7);
      chk("store_mem_ops",   mem_ops,        32'd2);
`endif

      // Random traffic with random freezes and occasional reset.
      for (int i = 0; i < 400; i++) begin
         rand_in(1);
         rst = ($urandom_range(0, 63) == 0);
         step(($urandom_range(0, 2) == 0) || (i % 100 > 85));
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
